stgreg_hs: RTL

Parametrised handshaked pipeline-stage register for the core's pipeline: holds a P_WIDTH payload between two stages with valid/ready flow control, a 2-entry skid buffer so every output is registered, and a synchronous flush for branch/exception squash. It replaces fixed, always-advancing stage latches wherever a stage must stall or be killed.

---
 rtl/stgreg_hs.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stgreg_hs.sv
// Handshaked pipeline-stage register with 2-entry skid and flush.
// Define STGREG_PERF_EN to enable the stall/bubble perf counters.
module stgreg_hs #(
  parameter int P_WIDTH     = 32,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_valid,
  output logic                   ow_ready,
  input  logic [P_WIDTH-1:0]     iw_data,
  output logic                   ow_valid,
  input  logic                   iw_ready,
  output logic [P_WIDTH-1:0]     ow_data,
  input  logic                   iw_flush,
  input  logic                   iw_cnt_clr,
  output logic [P_CNT_WIDTH-1:0] ow_stall_cnt,
  output logic [P_CNT_WIDTH-1:0] ow_bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [P_WIDTH-1:0] main_q;
  logic [P_WIDTH-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign ow_valid = (state_q != ST_EMPTY);
  assign ow_ready = (state_q != ST_FULL);
  assign ow_data  = main_q;

  assign in_fire  = iw_valid & ow_ready;
  assign out_fire = ow_valid & iw_ready;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over everything and suppresses all data loads.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (iw_flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            ld_main_in = 1'b1;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            (in_fire & out_fire): begin
              ld_main_in = 1'b1;
            end
            (in_fire & ~out_fire): begin
              ld_skid = 1'b1;
              state_d = ST_FULL;
            end
            (~in_fire & out_fire): begin
              state_d = ST_EMPTY;
            end
            default: begin
            end
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            ld_main_skid = 1'b1;
            state_d      = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      main_q <= '0;
    end else if (ld_main_in) begin
      main_q <= iw_data;
    end else if (ld_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      skid_q <= '0;
    end else if (ld_skid) begin
      skid_q <= iw_data;
    end
  end

`ifdef STGREG_PERF_EN
  logic [P_CNT_WIDTH-1:0] stall_q;
  logic [P_CNT_WIDTH-1:0] bubble_q;
  logic                   stall_inc;
  logic                   bubble_inc;

  assign stall_inc  = ow_valid & ~iw_ready & ~(&stall_q);
  assign bubble_inc = ~ow_valid & ~(&bubble_q);

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      stall_q <= '0;
    end else if (iw_cnt_clr) begin
      stall_q <= '0;
    end else if (stall_inc) begin
      stall_q <= stall_q + P_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      bubble_q <= '0;
    end else if (iw_cnt_clr) begin
      bubble_q <= '0;
    end else if (bubble_inc) begin
      bubble_q <= bubble_q + P_CNT_WIDTH'(1);
    end
  end

  assign ow_stall_cnt  = stall_q;
  assign ow_bubble_cnt = bubble_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = iw_cnt_clr;
  assign ow_stall_cnt   = '0;
  assign ow_bubble_cnt  = '0;
`endif

endmodule
